branch_resolve_unit: RTL

Execute-stage consumer of the branch comparator flags.
- Drives the comparator's unsigned-select input from the branch funct3.
- Turns the returned equal/less-than flags into a taken decision.
- Checks that decision against the fetch-time prediction and issues a registered PC redirect plus a multi-cycle flush of younger instructions on mispredict.
- Owns a 2-bit saturating branch history table, read by fetch and updated at resolution.

---
 rtl/branch_resolve_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: taken decode from comparator flags, mispredict
// redirect with a timed flush of IF/ID, and a 2-bit saturating branch history table.
module branch_resolve_unit #(
  parameter int IDX_W     = 6,
  parameter int FLUSH_CYC = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_pc_i,
  output logic        pred_taken_o,
  input  logic        ex_valid_i,
  input  logic        ex_branch_i,
  input  logic        ex_jump_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_pc_i,
  input  logic [31:0] ex_target_i,
  input  logic        ex_pred_taken_i,
  input  logic        stall_i,
  output logic        BrUn_o,
  input  logic        BrEq_i,
  input  logic        BrLt_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        flush_o,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int CNT_W   = $clog2(FLUSH_CYC + 1);
  localparam int ENTRIES = 2 ** IDX_W;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_FLUSH = 1'b1;

  logic             state;
  logic [CNT_W-1:0] flushCnt;
  logic [1:0]       bht [ENTRIES];

  logic             legalBr;
  logic             brTaken;
  logic             taken;
  logic             resolveEv;
  logic             mispred;
  logic             bhtUpd;
  logic [31:0]      correctPc;
  logic [IDX_W-1:0] fetchIdx;
  logic [IDX_W-1:0] exIdx;
  logic             unusedBits;

  assign fetchIdx     = fetch_pc_i[IDX_W+1:2];
  assign exIdx        = ex_pc_i[IDX_W+1:2];
  assign pred_taken_o = bht[fetchIdx][1];
  assign unusedBits   = ^{fetch_pc_i[31:IDX_W+2], fetch_pc_i[1:0]};

  assign BrUn_o = ex_funct3_i[1];

  always_comb begin
    legalBr = 1'b1;
    brTaken = 1'b0;
    case (ex_funct3_i)
      3'b000:          brTaken = BrEq_i;
      3'b001:          brTaken = !BrEq_i;
      3'b100, 3'b110:  brTaken = BrLt_i;
      3'b101, 3'b111:  brTaken = !BrLt_i;
      default:         legalBr = 1'b0;
    endcase
  end

  // A jump overrides any branch decode, even when both flags arrive together.
  assign taken     = ex_jump_i ? 1'b1 : (ex_branch_i & legalBr & brTaken);
  assign resolveEv = ex_valid_i & !stall_i & (ex_branch_i | ex_jump_i) & (state == STATE_IDLE);
  assign mispred   = taken != ex_pred_taken_i;
  assign bhtUpd    = resolveEv & ex_branch_i & !ex_jump_i & legalBr;
  assign correctPc = taken ? ex_target_i : ex_pc_i + 32'd4;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= STATE_IDLE;
      flushCnt      <= '0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= 32'd0;
    end else begin
      redirect_o <= resolveEv & mispred;
      if (resolveEv & mispred) redirect_pc_o <= correctPc;
      case (state)
        STATE_IDLE: begin
          if (resolveEv & mispred) begin
            state    <= STATE_FLUSH;
            flushCnt <= CNT_W'(FLUSH_CYC);
          end
        end
        default: begin
          if (!stall_i) begin
            flushCnt <= flushCnt - 1'b1;
            if (flushCnt == CNT_W'(1)) state <= STATE_IDLE;
          end
        end
      endcase
    end
  end

  assign flush_o = (state == STATE_FLUSH);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o  <= 32'd0;
      mispred_cnt_o <= 32'd0;
    end else begin
      if (bhtUpd) branch_cnt_o <= branch_cnt_o + 32'd1;
      if (resolveEv & mispred) mispred_cnt_o <= mispred_cnt_o + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (bhtUpd) begin
      if (taken) begin
        if (bht[exIdx] != 2'b11) bht[exIdx] <= bht[exIdx] + 2'b01;
      end else begin
        if (bht[exIdx] != 2'b00) bht[exIdx] <= bht[exIdx] - 2'b01;
      end
    end
  end

endmodule
